ifft_cp_insert: RTL and testbench
=================================

# ifft_cp_insert

Cyclic-prefix inserter sitting directly downstream of the 64-point pipelined IFFT. Accepts one natural-order complex sample per input strobe, framed by the IFFT's sync pulse, and stores each 64-sample symbol in a ping-pong buffer. Emits each symbol prefixed by its last NCP samples (80 samples per symbol by default), one sample per output strobe, with a symbol-start sync. Decouples the IFFT's 64-per-symbol rate from the 80-per-symbol output rate.

## Interface
- LGNFFT, 6, log2 of symbol length (N = 64)
- NCP, 16, cyclic-prefix length; 1 ≤ NCP < N
- DW, 32, sample width: real in [DW-1:DW/2], imaginary in [DW/2-1:0], two's complement

- i_clk  in  1  clock; all logic on the rising edge
- i_reset  in  1  reset, synchronous, active high
- i_ce  in  1  input strobe; i_sync and i_sample are valid in this cycle
- i_sync  in  1  first sample of a symbol; qualified by i_ce
- i_sample  in  DW  IFFT output sample
- i_out_ce  in  1  output strobe from the downstream consumer
- o_valid  out  1  o_result/o_sync valid this cycle
- o_result  out  DW  output sample
- o_sync  out  1  first cyclic-prefix sample of a symbol
- o_overflow  out  1  sticky: a symbol was dropped

## Operation
- Reset values: o_valid=0, o_sync=0, o_overflow=0, o_result=0. Both banks empty, write and read bank select = 0, writer in WAIT_SYNC.
- Writer states: WAIT_SYNC and WRITE.
  - WAIT_SYNC: discard i_ce samples until i_ce&i_sync.
  - WRITE: samples are written at wr_idx 0..N-1.
  - The i_sync sample is always idx 0.
  - i_sync at wr_idx≠0 (resync): discard the partial symbol and restart at idx 0 in the same bank. o_overflow is unaffected.
  - At idx 0, if the target bank is still full, the whole symbol is dropped (no writes, o_overflow←1) and the writer returns to WAIT_SYNC. A release of that bank by the reader in the same cycle counts as free, and the symbol is accepted.
  - Writing idx N-1 sets that bank's full flag and toggles the write bank.
- Reader states: IDLE and OUT.
  - Leaves IDLE when i_out_ce is high and the read bank's registered full flag = 1.
  - Each i_out_ce in OUT issues one read.
  - Read order: addresses N-NCP..N-1, then 0..N-1, giving N+NCP reads.
  - The last read clears the bank's full flag and toggles the read bank. The reader then goes to IDLE, or continues directly into the next bank's first read on the next i_out_ce if that bank is full.
  - Banks are read strictly in write order.
- Output register: o_valid is set at the edge after an issued read and held high for exactly one cycle per read.
  - o_result carries the RAM data.
  - o_sync=1 only on the first CP read.
  - i_out_ce with no full bank gives o_valid=0 (gap between symbols; o_result holds).
- Data path: no arithmetic; samples pass bit-exact.
- Rate rule: sustained throughput requires ≥ (N+NCP) i_out_ce per N i_ce. Violation yields dropped symbols, never corrupted ones.

## Timing
- Write: the sample is stored on the i_ce edge. The full flag is visible the cycle after idx N-1 is written.
- Read latency: 1 cycle from i_out_ce to o_valid/o_result.
- Minimum latency from the last input sample to the first output sample (o_valid): 2 cycles.
- Reset mid-operation: everything returns to the reset state on the next edge. Partial symbols and buffered symbols are discarded, and no further o_valid occurs until a new full symbol is written.

## Structure
- Shared package constants: N, NCP, DW, and the derived NOUT = N+NCP.
- The writer and reader state encodings live with the block.
- One sub-module, cp_bufram: a 2N×DW simple dual-port RAM. It has one write port and one registered read port, with address {bank, idx}.

## Test plan
- Single symbol with i_sample = idx (0..63) and i_out_ce held high → 80 outputs: 48..63 then 0..63. o_sync only on the first output (48). o_valid first rises 2 cycles after idx 63 is written.
- Continuous symbols at i_ce 4/5 duty with i_out_ce always high, 10 symbols → 800 gap-free-per-symbol outputs in order, o_overflow=0.
- i_out_ce held low while 3 symbols arrive → symbols 1 and 2 buffered, symbol 3 dropped, o_overflow=1. Releasing i_out_ce then gives 160 outputs for symbols 1 and 2.
- i_sync reasserted at idx 20 → partial symbol discarded. The next 64 samples form a symbol, and its output is CP plus those samples only.
- i_ce samples before the first i_sync (values 0xDEAD…) → never appear at the output.
- i_reset pulsed during output sample 30 → o_valid=0 next cycle and no further output until a new full symbol is written. The next symbol outputs correctly from its CP start.

Source files
------------

// File: rtl/ifft_cp_insert_pkg.sv
// Cyclic-prefix inserter shared constants.
// Symbol geometry and sample width.
package ifft_cp_insert_pkg;
  localparam int LGNFFT = 6;
  localparam int N      = 1 << LGNFFT;
  localparam int NCP    = 16;
  localparam int DW     = 32;
  localparam int NOUT   = N + NCP;
  localparam int CW     = $clog2(NOUT);
  localparam int AW     = LGNFFT + 1;
endpackage

// File: rtl/ifft_cp_insert_bufram.sv
// Ping-pong sample store: 2N x DW simple dual-port RAM.
// Address is {bank, idx}; read data is registered and holds between reads.
module cp_bufram
  import ifft_cp_insert_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] mem [2*N];
  logic [DW-1:0] rdata_d;
  logic [DW-1:0] rdata_q;

  // Write port
  always_ff @(posedge i_clk) begin
    if (i_we) mem[i_waddr] <= i_wdata;
  end

  // Read data only changes on an issued read
  always_comb begin
    rdata_d = rdata_q;
    if (i_re) rdata_d = mem[i_raddr];
  end

  // Read output register
  always_ff @(posedge i_clk) begin
    if (i_reset) rdata_q <= '0;
    else         rdata_q <= rdata_d;
  end

  assign o_rdata = rdata_q;

endmodule

// File: rtl/ifft_cp_insert.sv
// Cyclic-prefix inserter behind the 64-point IFFT.
// Buffers symbols in two banks and replays each with its tail prepended.
module ifft_cp_insert
  import ifft_cp_insert_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_ce,
  input  logic          i_sync,
  input  logic [DW-1:0] i_sample,
  input  logic          i_out_ce,
  output logic          o_valid,
  output logic [DW-1:0] o_result,
  output logic          o_sync,
  output logic          o_overflow
);

  typedef enum logic {W_WAIT_SYNC, W_WRITE} wst_e;
  typedef enum logic {R_IDLE, R_OUT} rst_e;

  wst_e              wst_d, wst_q;
  logic [LGNFFT-1:0] wr_idx_d, wr_idx_q;
  logic              wbank_d, wbank_q;
  logic [1:0]        full_d, full_q;
  rst_e              rdst_d, rdst_q;
  logic [CW-1:0]     rd_cnt_d, rd_cnt_q;
  logic              rbank_d, rbank_q;
  logic              valid_d, valid_q;
  logic              sync_d, sync_q;
  logic              ovf_d, ovf_q;

  logic              rd_issue;
  logic              rd_last;
  logic [LGNFFT-1:0] rd_idx;
  logic              bank_free;
  logic              set_full;
  logic              we;
  logic [AW-1:0]     waddr;

  // Reader: CP tail first, then the whole symbol, bank by bank
  always_comb begin
    rdst_d   = rdst_q;
    rd_cnt_d = rd_cnt_q;
    rbank_d  = rbank_q;
    rd_issue = i_out_ce && (rdst_q == R_OUT || full_q[rbank_q]);
    rd_last  = rd_issue && (rd_cnt_q == CW'(NOUT - 1));
    if (rd_cnt_q < CW'(NCP)) rd_idx = LGNFFT'(rd_cnt_q + CW'(N - NCP));
    else                     rd_idx = LGNFFT'(rd_cnt_q - CW'(NCP));
    if (rd_issue) begin
      if (rd_last) begin
        rd_cnt_d = '0;
        rbank_d  = ~rbank_q;
        rdst_d   = full_q[~rbank_q] ? R_OUT : R_IDLE;
      end else begin
        rd_cnt_d = rd_cnt_q + 1'b1;
        rdst_d   = R_OUT;
      end
    end
    valid_d = rd_issue;
    sync_d  = rd_issue && (rd_cnt_q == '0);
  end

  // Writer: frame on sync, drop whole symbols when the bank is busy
  always_comb begin
    wst_d     = wst_q;
    wr_idx_d  = wr_idx_q;
    wbank_d   = wbank_q;
    ovf_d     = ovf_q;
    set_full  = 1'b0;
    we        = 1'b0;
    waddr     = {wbank_q, wr_idx_q};
    bank_free = !full_q[wbank_q] || (rd_last && rbank_q == wbank_q);
    if (i_ce) begin
      unique case (wst_q)
        W_WAIT_SYNC: begin
          if (i_sync) begin
            if (bank_free) begin
              we       = 1'b1;
              waddr    = {wbank_q, {LGNFFT{1'b0}}};
              wr_idx_d = LGNFFT'(1);
              wst_d    = W_WRITE;
            end else begin
              ovf_d = 1'b1;
            end
          end
        end
        W_WRITE: begin
          we = 1'b1;
          if (i_sync) begin
            waddr    = {wbank_q, {LGNFFT{1'b0}}};
            wr_idx_d = LGNFFT'(1);
          end else if (wr_idx_q == LGNFFT'(N - 1)) begin
            set_full = 1'b1;
            wbank_d  = ~wbank_q;
            wr_idx_d = '0;
            wst_d    = W_WAIT_SYNC;
          end else begin
            wr_idx_d = wr_idx_q + 1'b1;
          end
        end
      endcase
    end
  end

  // Bank occupancy: reader releases, writer fills
  always_comb begin
    full_d = full_q;
    if (rd_last)  full_d[rbank_q] = 1'b0;
    if (set_full) full_d[wbank_q] = 1'b1;
  end

  // State and output registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wst_q    <= W_WAIT_SYNC;
      wr_idx_q <= '0;
      wbank_q  <= 1'b0;
      full_q   <= '0;
      rdst_q   <= R_IDLE;
      rd_cnt_q <= '0;
      rbank_q  <= 1'b0;
      valid_q  <= 1'b0;
      sync_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wst_q    <= wst_d;
      wr_idx_q <= wr_idx_d;
      wbank_q  <= wbank_d;
      full_q   <= full_d;
      rdst_q   <= rdst_d;
      rd_cnt_q <= rd_cnt_d;
      rbank_q  <= rbank_d;
      valid_q  <= valid_d;
      sync_q   <= sync_d;
      ovf_q    <= ovf_d;
    end
  end

  cp_bufram u_ram (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_we    (we),
    .i_waddr (waddr),
    .i_wdata (i_sample),
    .i_re    (rd_issue),
    .i_raddr ({rbank_q, rd_idx}),
    .o_rdata (o_result)
  );

  assign o_valid    = valid_q;
  assign o_sync     = sync_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_ifft_cp_insert.sv
// Bench for ifft_cp_insert: symbol-level output model plus literal checks.
// Expected stream = CP tail then full symbol for every accepted symbol.
module tb_ifft_cp_insert;

  localparam int TN   = 64;
  localparam int TNCP = 16;

  logic        i_clk;
  logic        i_reset;
  logic        i_ce;
  logic        i_sync;
  logic [31:0] i_sample;
  logic        i_out_ce;
  logic        o_valid;
  logic [31:0] o_result;
  logic        o_sync;
  logic        o_overflow;

  ifft_cp_insert dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_ce       (i_ce),
    .i_sync     (i_sync),
    .i_sample   (i_sample),
    .i_out_ce   (i_out_ce),
    .o_valid    (o_valid),
    .o_result   (o_result),
    .o_sync     (o_sync),
    .o_overflow (o_overflow)
  );

  typedef struct packed {
    logic [31:0] d;
    logic        s;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] got_d[$];
  logic        got_s[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          t_last = 0;
  int          gaps = 0;
  int          ph = 0;
  logic        prev_valid = 1'b0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) cyc <= cyc + 1;

  function automatic logic [31:0] sv(int id, int idx);
    return {id[15:0], idx[15:0]};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic push_sym(int id);
    for (int k = 0; k < TN + TNCP; k++) begin
      int idx;
      exp_t e;
      idx = (k < TNCP) ? (TN - TNCP + k) : (k - TNCP);
      e.d = sv(id, idx);
      e.s = (k == 0);
      exp_q.push_back(e);
    end
  endtask

  task automatic cyc_in(logic ce, logic sy, logic [31:0] d);
    i_ce     = ce;
    i_sync   = sy;
    i_sample = d;
    t_last   = cyc;
    @(posedge i_clk);
    #1;
    i_ce   = 1'b0;
    i_sync = 1'b0;
  endtask

  task automatic send_sym(int id, bit duty);
    for (int i = 0; i < TN; i++) begin
      if (duty && ph == 4) begin
        cyc_in(1'b0, 1'b0, 32'h0);
        ph = 0;
      end
      cyc_in(1'b1, i == 0, sv(id, i));
      if (duty) ph++;
    end
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    exp_q.delete();
    ph = 0;
  endtask

  task automatic wait_drain(int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      @(posedge i_clk);
      k++;
    end
    #1;
    chk("drain_done", exp_q.size(), 0);
    repeat (4) @(posedge i_clk);
    #1;
  endtask

  // Output compare against the expected stream
  always @(negedge i_clk) begin
    if (o_valid === 1'b1) begin
      got_d.push_back(o_result);
      got_s.push_back(o_sync);
      if (!prev_valid && o_sync !== 1'b1) gaps++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_valid: got %h sync %b want no output",
                 o_result, o_sync);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (o_result !== e.d || o_sync !== e.s) begin
          n_bad++;
          $display("FAIL stream: got %h sync %b want %h sync %b",
                   o_result, o_sync, e.d, e.s);
        end
      end
    end
    prev_valid = (o_valid === 1'b1);
  end

  initial begin
    int base;
    int k;
    i_reset  = 1'b1;
    i_ce     = 1'b0;
    i_sync   = 1'b0;
    i_sample = '0;
    i_out_ce = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    chk("rst_valid", o_valid, 0);
    chk("rst_sync", o_sync, 0);
    chk("rst_ovf", o_overflow, 0);
    chk("rst_result", o_result, 0);

    // Single symbol, sample = idx
    i_out_ce = 1'b1;
    base = got_d.size();
    push_sym(0);
    send_sym(0, 1'b0);
    k = 0;
    while (k < 10) begin
      @(negedge i_clk);
      if (o_valid === 1'b1) break;
      k++;
    end
    chk("t1_latency", cyc - t_last, 2);
    wait_drain(200);
    chk("t1_count", got_d.size() - base, 80);
    chk("t1_first", got_d[base], 48);
    chk("t1_first_sync", got_s[base], 1);
    chk("t1_second_sync", got_s[base + 1], 0);
    chk("t1_cp_last", got_d[base + 15], 63);
    chk("t1_body_first", got_d[base + 16], 0);
    chk("t1_last", got_d[base + 79], 63);

    // Ten symbols at 4/5 input duty
    base = got_d.size();
    for (int s = 0; s < 10; s++) push_sym(16'h21 + s);
    for (int s = 0; s < 10; s++) send_sym(16'h21 + s, 1'b1);
    wait_drain(3000);
    chk("t2_count", got_d.size() - base, 800);
    chk("t2_ovf", o_overflow, 0);
    chk("t2_gaps", gaps, 0);

    // Consumer stalled: third symbol dropped
    do_reset();
    i_out_ce = 1'b0;
    base = got_d.size();
    push_sym(16'h31);
    push_sym(16'h32);
    send_sym(16'h31, 1'b0);
    send_sym(16'h32, 1'b0);
    send_sym(16'h33, 1'b0);
    repeat (5) @(posedge i_clk);
    #1;
    chk("t3_ovf", o_overflow, 1);
    chk("t3_no_out", got_d.size() - base, 0);
    i_out_ce = 1'b1;
    wait_drain(400);
    chk("t3_count", got_d.size() - base, 160);
    chk("t3_ovf_sticky", o_overflow, 1);

    // Resync at idx 20
    do_reset();
    chk("t4_ovf_clr", o_overflow, 0);
    base = got_d.size();
    for (int i = 0; i < 20; i++) cyc_in(1'b1, i == 0, sv(16'h44, i));
    push_sym(16'h45);
    send_sym(16'h45, 1'b0);
    wait_drain(200);
    chk("t4_count", got_d.size() - base, 80);
    chk("t4_ovf", o_overflow, 0);

    // Samples before the first sync
    do_reset();
    base = got_d.size();
    for (int i = 0; i < 10; i++) cyc_in(1'b1, 1'b0, 32'hDEAD0000 + i);
    push_sym(16'h55);
    send_sym(16'h55, 1'b0);
    wait_drain(200);
    chk("t5_count", got_d.size() - base, 80);

    // Reset during output sample 30
    do_reset();
    base = got_d.size();
    push_sym(16'h66);
    send_sym(16'h66, 1'b0);
    k = 0;
    while (k < 300) begin
      @(negedge i_clk);
      #2;
      if (got_d.size() - base >= 30) break;
      k++;
    end
    i_reset = 1'b1;
    @(posedge i_clk);
    #1;
    i_reset = 1'b0;
    exp_q.delete();
    chk("t6_seen", got_d.size() - base, 30);
    chk("t6_valid_off", o_valid, 0);
    repeat (20) @(posedge i_clk);
    #1;
    chk("t6_quiet", got_d.size() - base, 30);
    base = got_d.size();
    push_sym(16'h67);
    send_sym(16'h67, 1'b0);
    wait_drain(200);
    chk("t6_count", got_d.size() - base, 80);
    chk("t6_first", got_d[base], sv(16'h67, 48));
    chk("t6_first_sync", got_s[base], 1);

    chk("final_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
